// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  localparam int unsigned DATA_W = 32;

  // A queue entry carries one instruction word plus the PC it was fetched from.
  localparam int unsigned ENTRY_W = 2 * DATA_W;

  localparam int unsigned RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with occupancy count and a flush input.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, wrPtr_q;
  logic [AW:0]   count_q;
  logic          doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rdPtr_q];
  assign doPush  = push_i & (~full_o | pop_i);
  assign doPop   = pop_i & ~empty_o;

  // Entry storage needs no reset; valid contents are tracked by the count.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  // Pointers wrap naturally at DEPTH; clear empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: PC generation, memory issue, prefetch queue and redirect flush.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              N        = DATA_W,
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 4,
  parameter logic [N-1:0]    RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_data,
  input  logic              redirect,
  input  logic [N-1:0]      redirect_pc,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [N-1:0]      ir,
  output logic [N-1:0]      ir_pc,
  output logic [N-1:0]      ir_npc
);

  localparam int EW = (ENTRY_W / DATA_W) * N;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [N-1:0]  fetchPc_q, fetchPc_d;
  logic [N-1:0]  tagPc_q;
  logic          inflight_q;
  logic          push, pop;
  logic [CW-1:0] fifoCount;
  logic [CW:0]   occupancy;
  logic          fifoEmpty, fifoFull;
  logic [EW-1:0] fifoDout;

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .din_i   ({imem_data, tagPc_q}),
    .dout_o  (fifoDout),
    .count_o (fifoCount),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, inflight_q};
  assign imem_addr = fetchPc_q[ADDR_W-1:0];
  assign ir_valid  = ~fifoEmpty;
  assign ir        = ir_valid ? fifoDout[EW-1:N] : '0;
  assign ir_pc     = ir_valid ? fifoDout[N-1:0]  : '0;
  assign ir_npc    = ir_valid ? fifoDout[N-1:0] + 1'b1 : '0;

  // FSM, PC and the single in-flight tag; the response of the issue in cycle t lands in t+1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      fetchPc_q  <= RESET_PC;
      inflight_q <= 1'b0;
      tagPc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      inflight_q <= imem_req;
      if (imem_req) tagPc_q <= fetchPc_q;
    end
  end

  // Issue only from registered occupancy so ir_ready never reaches imem_req; redirect beats increment and pop.
  always_comb begin
    state_d   = RUN;
    fetchPc_d = fetchPc_q;
    push      = 1'b0;
    pop       = ir_valid & ir_ready & ~redirect;
    imem_req  = rst & ~fifoFull & (occupancy < (CW+1)'(DEPTH));
    if (imem_req) fetchPc_d = fetchPc_q + 1'b1;
    case (state_q)
      RUN:     push = inflight_q & ~redirect;
      FLUSH:   push = 1'b0;
      default: push = 1'b0;
    endcase
    if (redirect) begin
      fetchPc_d = redirect_pc;
      state_d   = FLUSH;
    end
  end

endmodule
